// File: rtl/uart_pkg.sv
// Shared UART definitions: receive FSM states, baud tick sizing and frame bit order.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP,
      DONE,
      BREAK
   } uart_state_e;

   // Data bits travel most significant bit first on the line.
   localparam bit MSB_FIRST = 1'b1;

   function automatic int unsigned calc_tick_limit(input int unsigned clock_freq,
                                                   input int unsigned baud_rate,
                                                   input int unsigned oversample);
      int unsigned limit;
      limit = clock_freq / (baud_rate * oversample);
      return (limit < 1) ? 1 : limit;
   endfunction

endpackage

// File: rtl/uart_receiver_if.sv
// Receive-side UART bundle: serial line in, recovered word and status pulses out.
interface uart_receiver_if #(
   parameter int unsigned WORD_SIZE = 8
);
   logic                 rx;
   logic [WORD_SIZE-1:0] data;
   logic                 rx_recv_i;
   logic                 frame_err;
   logic                 parity_err;

   modport master (input rx, output data, rx_recv_i, frame_err, parity_err);
   modport slave  (output rx, input data, rx_recv_i, frame_err, parity_err);
endinterface

// File: rtl/uart_baud_tick.sv
// Oversampling tick generator: one-cycle tick every TICK_LIMIT clocks, held at phase 0 by clear_i.
module uart_baud_tick #(
   parameter int unsigned TICK_LIMIT = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic clear_i,
   output logic tick_o
);
   localparam int CNT_W = (TICK_LIMIT > 1) ? $clog2(TICK_LIMIT) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_LIMIT - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   assign tick_o = !clear_i && (cnt_q == LAST);

   always_comb begin
      cnt_d = cnt_q;
      if (clear_i || tick_o) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // NOTE: registers take <= so every flop samples the pre-edge values of its inputs.
   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end
endmodule

// File: rtl/uart_receiver.sv
// UART receive path: start, WORD_SIZE data bits MSB first, stop, sampled mid-bit.
// Define UART_RX_PARITY_EN to expect an even-parity bit before the stop bit.
module uart_receiver
   import uart_pkg::*;
#(
   parameter int unsigned CLOCK_FREQ = 16_000_000,
   parameter int unsigned BAUD_RATE  = 1_000_000,
   parameter int unsigned WORD_SIZE  = 8,
   parameter int unsigned OVERSAMPLE = 16
) (
   input  logic           clk,
   input  logic           rst,
   uart_receiver_if.master bus
);
   localparam int unsigned TICK_LIMIT = calc_tick_limit(CLOCK_FREQ, BAUD_RATE, OVERSAMPLE);
   localparam int CNT_W = $clog2(OVERSAMPLE);
   localparam int BIT_W = (WORD_SIZE > 1) ? $clog2(WORD_SIZE) : 1;
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(OVERSAMPLE / 2 - 1);
   localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(OVERSAMPLE - 1);
   localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(WORD_SIZE - 1);

   logic                 rx_meta_q, rx_s_q;
   uart_state_e          state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [BIT_W-1:0]     bit_q, bit_d;
   logic [WORD_SIZE-1:0] shift_q, shift_d;
   logic [WORD_SIZE-1:0] data_q, data_d;
   logic                 recv_q, recv_d;
   logic                 ferr_q, ferr_d;
`ifdef UART_RX_PARITY_EN
   logic                 par_mis_q, par_mis_d;
   logic                 perr_q, perr_d;
`endif
   logic                 tick;
   logic                 tick_clear;
   logic                 sample;

   // Holding the tick phase at zero in IDLE aligns sampling to the detected start edge.
   assign tick_clear = (state_q == IDLE);

   uart_baud_tick #(.TICK_LIMIT(TICK_LIMIT)) u_baud_tick (
      .clk     (clk),
      .rst     (rst),
      .clear_i (tick_clear),
      .tick_o  (tick)
   );

   assign sample = tick && (cnt_q == ((state_q == START) ? HALF_LAST : FULL_LAST));

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      data_d  = data_q;
      recv_d  = 1'b0;
      ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
      par_mis_d = par_mis_q;
      perr_d    = 1'b0;
`endif
      if (state_q == IDLE) begin
         cnt_d = '0;
      end else if (tick) begin
         cnt_d = sample ? '0 : cnt_q + 1'b1;
      end

      case (state_q)
         IDLE: if (!rx_s_q) state_d = START;
         START: begin
            if (sample) begin
               state_d = rx_s_q ? IDLE : DATA;
               bit_d   = '0;
            end
         end
         DATA: begin
            if (sample) begin
               shift_d = MSB_FIRST ? {shift_q[WORD_SIZE-2:0], rx_s_q}
                                   : {rx_s_q, shift_q[WORD_SIZE-1:1]};
               bit_d   = bit_q + 1'b1;
               if (bit_q == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                  state_d = PARITY;
`else
                  state_d = STOP;
`endif
               end
            end
         end
`ifdef UART_RX_PARITY_EN
         PARITY: begin
            if (sample) begin
               par_mis_d = rx_s_q ^ (^shift_q);
               state_d   = STOP;
            end
         end
`endif
         STOP: begin
            if (sample) begin
               if (rx_s_q) begin
                  state_d = DONE;
               end else begin
                  ferr_d  = 1'b1;
                  state_d = BREAK;
               end
            end
         end
         DONE: begin
`ifdef UART_RX_PARITY_EN
            if (par_mis_q) begin
               perr_d = 1'b1;
            end else begin
               data_d = shift_q;
               recv_d = 1'b1;
            end
`else
            data_d = shift_q;
            recv_d = 1'b1;
`endif
            state_d = IDLE;
         end
         BREAK: if (rx_s_q) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         rx_meta_q <= 1'b1;
         rx_s_q    <= 1'b1;
         state_q   <= IDLE;
         cnt_q     <= '0;
         bit_q     <= '0;
         shift_q   <= '0;
         data_q    <= '0;
         recv_q    <= 1'b0;
         ferr_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_mis_q <= 1'b0;
         perr_q    <= 1'b0;
`endif
      end else begin
         rx_meta_q <= bus.rx;
         rx_s_q    <= rx_meta_q;
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         bit_q     <= bit_d;
         shift_q   <= shift_d;
         data_q    <= data_d;
         recv_q    <= recv_d;
         ferr_q    <= ferr_d;
`ifdef UART_RX_PARITY_EN
         par_mis_q <= par_mis_d;
         perr_q    <= perr_d;
`endif
      end
   end

   assign bus.data      = data_q;
   assign bus.rx_recv_i = recv_q;
   assign bus.frame_err = ferr_q;
`ifdef UART_RX_PARITY_EN
   assign bus.parity_err = perr_q;
`else
   assign bus.parity_err = 1'b0;
`endif
endmodule
